// File: rtl/zip_pkg.sv
// Shared constants, FSM state codes and the 32-bit generalized zip/unzip permutation
// used by the zip sequencer.
package zip_pkg;

    localparam int ZIP_XLEN   = 32;
    localparam int ZIP_MODE_W = 5;

    // mode[0] selects unzip order; mode[4:1] enable the 1/2/4/8-bit swap stages.
    localparam int ZIP_MODE_UNZIP = 0;
    localparam int ZIP_MODE_S1    = 1;
    localparam int ZIP_MODE_S2    = 2;
    localparam int ZIP_MODE_S4    = 3;
    localparam int ZIP_MODE_S8    = 4;

    localparam logic [1:0] ZIP_ST_IDLE = 2'd0;
    localparam logic [1:0] ZIP_ST_RUN  = 2'd1;
    localparam logic [1:0] ZIP_ST_DONE = 2'd2;

    function automatic logic [ZIP_XLEN-1:0] zip_stage(
        input logic [ZIP_XLEN-1:0] x,
        input logic [ZIP_XLEN-1:0] mask_l,
        input logic [ZIP_XLEN-1:0] mask_r,
        input int                  n
    );
        return (x & ~(mask_l | mask_r)) | ((x << n) & mask_l) | ((x >> n) & mask_r);
    endfunction

    // Each stage is self-inverse, so unzip is the zip stages applied in reverse order.
    function automatic logic [ZIP_XLEN-1:0] zip_genzip(
        input logic [ZIP_XLEN-1:0]   x,
        input logic [ZIP_MODE_W-1:0] mode
    );
        logic [ZIP_XLEN-1:0] y;
        y = x;
        if (!mode[ZIP_MODE_UNZIP]) begin
            if (mode[ZIP_MODE_S8]) y = zip_stage(y, 32'h00ff_0000, 32'h0000_ff00, 8);
            if (mode[ZIP_MODE_S4]) y = zip_stage(y, 32'h0f00_0f00, 32'h00f0_00f0, 4);
            if (mode[ZIP_MODE_S2]) y = zip_stage(y, 32'h3030_3030, 32'h0c0c_0c0c, 2);
            if (mode[ZIP_MODE_S1]) y = zip_stage(y, 32'h4444_4444, 32'h2222_2222, 1);
        end else begin
            if (mode[ZIP_MODE_S1]) y = zip_stage(y, 32'h4444_4444, 32'h2222_2222, 1);
            if (mode[ZIP_MODE_S2]) y = zip_stage(y, 32'h3030_3030, 32'h0c0c_0c0c, 2);
            if (mode[ZIP_MODE_S4]) y = zip_stage(y, 32'h0f00_0f00, 32'h00f0_00f0, 4);
            if (mode[ZIP_MODE_S8]) y = zip_stage(y, 32'h00ff_0000, 32'h0000_ff00, 8);
        end
        return y;
    endfunction

endpackage

// File: rtl/zip_rr_arb.sv
// Rotating-priority arbiter: grants the first valid requester at or after the pointer,
// and moves the pointer past the winner whenever a grant is taken.
module zip_rr_arb #(
    parameter int NREQ = 2,
    parameter int IDW  = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_en,
    input  logic [NREQ-1:0] i_valid,
    output logic [NREQ-1:0] o_grant,
    output logic [IDW-1:0]  o_id,
    output logic            o_any
);

    logic [IDW-1:0] r_ptr;
    int             w_idx;

    // NOTE: every output of this block gets a default first, so no path infers a latch.
    always_comb begin
        o_grant = '0;
        o_id    = '0;
        o_any   = 1'b0;
        w_idx   = 0;
        for (int off = 0; off < NREQ; off++) begin
            w_idx = int'(r_ptr) + off;
            if (w_idx >= NREQ) w_idx = w_idx - NREQ;
            if (!o_any && i_valid[w_idx[IDW-1:0]]) begin
                o_any = 1'b1;
                o_id  = w_idx[IDW-1:0];
            end
        end
        if (i_en && o_any) o_grant[o_id] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (i_en && o_any) begin
            r_ptr <= (o_id == IDW'(NREQ - 1)) ? '0 : o_id + IDW'(1);
        end
    end

endmodule

// File: rtl/zip_seq_ctrl.sv
// Sequencer owning one genzip datapath: arbitrates requesters, iterates the permutation,
// returns the result. Define ZIP_SEQ_EARLY_EXIT_EN to stop as soon as the operand recurs.
module zip_seq_ctrl
    import zip_pkg::*;
#(
    parameter int  NREQ   = 2,
    parameter int  ITER_W = 4,
    localparam int IDW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NREQ-1:0]              req_valid,
    output logic [NREQ-1:0]              req_ready,
    input  logic [ZIP_XLEN*NREQ-1:0]     req_data,
    input  logic [ZIP_MODE_W*NREQ-1:0]   req_mode,
    input  logic [ITER_W*NREQ-1:0]       req_iters,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [ZIP_XLEN-1:0]          out_data,
    output logic [IDW-1:0]               out_id,
    output logic [ITER_W-1:0]            out_iters,
    output logic                         out_early
);

    logic [1:0]            r_state;
    logic [ZIP_XLEN-1:0]   r_acc;
    logic [ZIP_MODE_W-1:0] r_mode;
    logic [ITER_W-1:0]     r_cnt;
    logic [ITER_W-1:0]     r_done;
    logic [IDW-1:0]        r_id;
    logic                  r_out_valid;
    logic [ZIP_XLEN-1:0]   r_out_data;
    logic [IDW-1:0]        r_out_id;
    logic [ITER_W-1:0]     r_out_iters;
    logic                  r_out_early;

    logic                  w_idle;
    logic                  w_any;
    logic                  w_take;
    logic [IDW-1:0]        w_id;
    logic [ZIP_XLEN-1:0]   w_sel_data;
    logic [ZIP_MODE_W-1:0] w_sel_mode;
    logic [ITER_W-1:0]     w_sel_iters;
    logic [ZIP_XLEN-1:0]   w_next;
    logic                  w_early_hit;
    logic                  w_last;

    zip_rr_arb #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .clk     (clk),
        .reset   (reset),
        .i_en    (w_idle),
        .i_valid (req_valid),
        .o_grant (req_ready),
        .o_id    (w_id),
        .o_any   (w_any)
    );

    assign w_idle      = (r_state == ZIP_ST_IDLE);
    assign w_take      = w_idle && w_any;
    assign w_sel_data  = req_data[ZIP_XLEN*int'(w_id) +: ZIP_XLEN];
    assign w_sel_mode  = req_mode[ZIP_MODE_W*int'(w_id) +: ZIP_MODE_W];
    assign w_sel_iters = req_iters[ITER_W*int'(w_id) +: ITER_W];
    assign w_next      = zip_genzip(r_acc, r_mode);

`ifdef ZIP_SEQ_EARLY_EXIT_EN
    logic [ZIP_XLEN-1:0] r_orig;

    always_ff @(posedge clk) begin
        if (w_take) r_orig <= w_sel_data;
    end

    // A match on the final pass is an ordinary completion, not an early one.
    assign w_early_hit = (w_next == r_orig) && (r_cnt != ITER_W'(1));
`else
    assign w_early_hit = 1'b0;
`endif

    assign w_last = (r_cnt == ITER_W'(1)) || w_early_hit;

    // NOTE: operand/count registers are always loaded at grant before use, so they carry no reset.
    always_ff @(posedge clk) begin
        if (w_take) begin
            r_acc  <= w_sel_data;
            r_mode <= w_sel_mode;
            r_cnt  <= w_sel_iters;
            r_done <= '0;
            r_id   <= w_id;
        end else if (r_state == ZIP_ST_RUN) begin
            r_acc  <= w_next;
            r_cnt  <= r_cnt - ITER_W'(1);
            r_done <= r_done + ITER_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ZIP_ST_IDLE;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_id    <= '0;
            r_out_iters <= '0;
            r_out_early <= 1'b0;
        end else begin
            case (r_state)
                ZIP_ST_IDLE: begin
                    if (w_take) begin
                        if (w_sel_iters == '0) begin
                            r_state     <= ZIP_ST_DONE;
                            r_out_valid <= 1'b1;
                            r_out_data  <= w_sel_data;
                            r_out_id    <= w_id;
                            r_out_iters <= '0;
                            r_out_early <= 1'b0;
                        end else begin
                            r_state <= ZIP_ST_RUN;
                        end
                    end
                end
                ZIP_ST_RUN: begin
                    if (w_last) begin
                        r_state     <= ZIP_ST_DONE;
                        r_out_valid <= 1'b1;
                        r_out_data  <= w_next;
                        r_out_id    <= r_id;
                        r_out_iters <= r_done + ITER_W'(1);
                        r_out_early <= w_early_hit;
                    end
                end
                ZIP_ST_DONE: begin
                    if (out_ready) begin
                        r_state     <= ZIP_ST_IDLE;
                        r_out_valid <= 1'b0;
                    end
                end
                default: r_state <= ZIP_ST_IDLE;
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_id    = r_out_id;
    assign out_iters = r_out_iters;
    assign out_early = r_out_early;

endmodule

// File: tb/tb_zip_seq_ctrl.sv
// Self-checking bench for zip_seq_ctrl: directed and random requests compared against
// an index-permutation reference model. Honours ZIP_SEQ_EARLY_EXIT_EN like the design.
module tb_zip_seq_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  req_valid = '0;
    logic [1:0]  req_ready;
    logic [63:0] req_data = '0;
    logic [9:0]  req_mode = '0;
    logic [7:0]  req_iters = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic [0:0]  out_id;
    logic [3:0]  out_iters;
    logic        out_early;

    int          n_chk = 0;
    int          n_bad = 0;
    logic [31:0] last_data;
    logic [3:0]  last_iters;
    logic        last_early;

    zip_seq_ctrl #(.NREQ(2), .ITER_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .req_mode  (req_mode),
        .req_iters (req_iters),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_id    (out_id),
        .out_iters (out_iters),
        .out_early (out_early)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%08h exp=0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: a zip stage of width 2^s swaps bit-index bits s and s+1.
    function automatic logic [31:0] ref_zip(input logic [31:0] x, input logic [4:0] mode);
        logic [31:0] y;
        int          j;
        int          lo;
        y = '0;
        for (int i = 0; i < 32; i++) begin
            j = i;
            for (int s = 0; s < 4; s++) begin
                lo = mode[0] ? s : 3 - s;
                if (mode[lo + 1] && (((j >> lo) & 1) != ((j >> (lo + 1)) & 1)))
                    j = j ^ (3 << lo);
            end
            y[j] = x[i];
        end
        return y;
    endfunction

    task automatic ref_run(input logic [31:0] d, input logic [4:0] m, input logic [3:0] it,
                           output logic [31:0] r, output logic [3:0] n, output logic early);
        r = d;
        n = '0;
        early = 1'b0;
        for (int p = 1; p <= int'(it); p++) begin
            r = ref_zip(r, m);
            n = 4'(p);
`ifdef ZIP_SEQ_EARLY_EXIT_EN
            if (r == d && p < int'(it)) begin
                early = 1'b1;
                break;
            end
`endif
        end
    endtask

    task automatic set_req(input int k, input logic [31:0] d, input logic [4:0] m,
                           input logic [3:0] it);
        req_data[32*k +: 32] = d;
        req_mode[5*k +: 5]   = m;
        req_iters[4*k +: 4]  = it;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_valid"}, out_valid, 0);
        check({tag, "_data"}, out_data, 0);
        check({tag, "_id"}, out_id, 0);
        check({tag, "_iters"}, out_iters, 0);
        check({tag, "_early"}, out_early, 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check_zero_outputs("rst");
        check("rst_ready", req_ready, 0);
    endtask

    // One request from requester k; optionally hold off out_ready and raise the other requester.
    task automatic txn(input int k, input logic [31:0] d, input logic [4:0] m, input logic [3:0] it,
                       input int hold, input bit raise_other);
        logic [31:0] e_data;
        logic [3:0]  e_it;
        logic        e_early;
        int          c;
        ref_run(d, m, it, e_data, e_it, e_early);
        set_req(k, d, m, it);
        req_valid[k] = 1'b1;
        #1;
        c = 0;
        while (!req_ready[k]) begin
            @(negedge clk);
            #1;
            c++;
            if (c > 40) begin
                check("grant_wait", 0, 1);
                req_valid[k] = 1'b0;
                return;
            end
        end
        @(negedge clk);
        req_valid[k] = 1'b0;
        c = 1;
        while (!out_valid && c <= 40) begin
            @(negedge clk);
            c++;
        end
        check("latency", c, e_it + 1);
        if (!out_valid) return;
        if (raise_other) begin
            set_req(1 - k, 32'h0, 5'h0, 4'h0);
            req_valid[1 - k] = 1'b1;
        end
        for (int h = 0; h < hold; h++) begin
            #1;
            check("hold_valid", out_valid, 1);
            check("hold_data", out_data, e_data);
            check("hold_ready", req_ready, 0);
            @(negedge clk);
        end
        #1;
        check("data", out_data, e_data);
        check("id", out_id, k);
        check("iters", out_iters, e_it);
        check("early", out_early, e_early);
        last_data  = out_data;
        last_iters = out_iters;
        last_early = out_early;
        out_ready = 1'b1;
        #1;
        check("accept_ready", req_ready, 0);
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        check("valid_drop", out_valid, 0);
        check("post_data", out_data, e_data);
        if (raise_other) check("next_grant", req_ready, 2'b01 << (1 - k));
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            check("ready_onehot0", $onehot0(req_ready), 1);
            if (out_valid) check("ready_in_done", req_ready, 0);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] e_a;
        logic [31:0] e_b;
        logic [3:0]  n_tmp;
        logic        f_tmp;
        int          got;
        int          c;

        do_reset();

        // Both requesters valid from reset: strict alternation starting at 0.
        set_req(0, 32'hCAFE_0001, 5'b11110, 4'd2);
        set_req(1, 32'h0BAD_F00D, 5'b10101, 4'd2);
        ref_run(32'hCAFE_0001, 5'b11110, 4'd2, e_a, n_tmp, f_tmp);
        ref_run(32'h0BAD_F00D, 5'b10101, 4'd2, e_b, n_tmp, f_tmp);
        req_valid = 2'b11;
        out_ready = 1'b1;
        got = 0;
        c = 0;
        while (got < 4 && c < 100) begin
            @(negedge clk);
            #1;
            c++;
            if (out_valid) begin
                check("rr_id", out_id, got % 2);
                check("rr_data", out_data, (got % 2) ? e_b : e_a);
                got++;
            end
        end
        check("rr_count", got, 4);
        @(negedge clk);
        req_valid = 2'b00;
        out_ready = 1'b0;
        @(negedge clk);

        // Spec examples.
        txn(0, 32'h0000_FFFF, 5'b11110, 4'd1, 0, 0);
        check("t1_data", last_data, 32'h5555_5555);
        check("t1_iters", last_iters, 1);
        txn(1, 32'h5555_5555, 5'b11111, 4'd1, 0, 0);
        check("t2_data", last_data, 32'h0000_FFFF);
        txn(0, 32'h5555_5555, 5'b11111, 4'd0, 0, 0);
        check("t2_zero", last_data, 32'h5555_5555);
        txn(1, 32'h1234_5678, 5'b11110, 4'd5, 0, 0);
        check("t3_data5", last_data, 32'h1234_5678);
        check("t3_early5", last_early, 0);
        txn(0, 32'h1234_5678, 5'b11110, 4'd15, 0, 0);
        check("t3_data15", last_data, 32'h1234_5678);
`ifdef ZIP_SEQ_EARLY_EXIT_EN
        check("t3_iters15", last_iters, 5);
        check("t3_early15", last_early, 1);
`else
        check("t3_iters15", last_iters, 15);
        check("t3_early15", last_early, 0);
`endif
        txn(1, 32'hA5A5_0F0F, 5'b00001, 4'd3, 0, 0);
        check("ident_data", last_data, 32'hA5A5_0F0F);

        // Back-pressure in DONE with the other requester waiting.
        txn(0, 32'h8765_4321, 5'b01100, 4'd2, 3, 1);
        txn(1, 32'h1357_9BDF, 5'b11010, 4'd0, 0, 0);

        for (int r = 0; r < 30; r++) begin
            txn(int'($urandom_range(0, 1)), $urandom, 5'($urandom_range(0, 31)),
                4'($urandom_range(0, 15)), int'($urandom_range(0, 3)), 0);
        end

        // Reset in the middle of a long run discards it and rewinds the pointer.
        set_req(0, 32'hDEAD_BEEF, 5'b11110, 4'd10);
        req_valid[0] = 1'b1;
        #1;
        c = 0;
        while (!req_ready[0] && c < 40) begin
            @(negedge clk);
            #1;
            c++;
        end
        check("rst_run_grant", req_ready, 2'b01);
        @(negedge clk);
        req_valid[0] = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 15; i++) begin
            #1;
            check("rst_run_novalid", out_valid, 0);
            @(negedge clk);
        end
        #1;
        check_zero_outputs("rst_run");
        set_req(1, 32'h0, 5'h0, 4'h0);
        req_valid = 2'b11;
        #1;
        check("rst_run_ptr", req_ready, 2'b01);
        req_valid = 2'b00;
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
